// File: rtl/stage_d_fifo.sv
// Handshake FIFO stage: buffers DIR/ack_prev words, re-offers them + INCREMENT on DOR.
// Optional STAGE_D_CHECKSUM_EN adds an XOR checksum of every downstream-acked word.
module stage_d_fifo #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [7:0]  INCREMENT = 8'd1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     DIR,
    input  logic [7:0]               data_in,
    output logic                     ack_prev,
    output logic                     DOR,
    output logic [7:0]               data_out,
    input  logic                     ack_from_next,
`ifdef STAGE_D_CHECKSUM_EN
    output logic [7:0]               checksum,
`endif
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_WAIT = 1'b1
    } tx_state_e;

    tx_state_e         state_q, state_d;
    logic [7:0]        mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ack_prev_q, ack_prev_d;
    logic              dor_q, dor_d;
    logic [7:0]        data_out_q, data_out_d;
    logic              push, pop;

    // No capture while ack_prev is high: upstream still holds DIR that cycle.
    always_comb begin
        push       = DIR && !full_q && !ack_prev_q;
        ack_prev_d = push;
        pop        = 1'b0;
        state_d    = state_q;
        dor_d      = dor_q;
        data_out_d = data_out_q;
        unique case (state_q)
            TX_IDLE: begin
                if (!empty_q) begin
                    pop        = 1'b1;
                    data_out_d = mem_q[rd_ptr_q] + INCREMENT;
                    dor_d      = 1'b1;
                    state_d    = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (ack_from_next) begin
                    dor_d      = 1'b0;
                    data_out_d = '0;
                    state_d    = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= TX_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ack_prev_q <= 1'b0;
            dor_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            ack_prev_q <= ack_prev_d;
            dor_q      <= dor_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef STAGE_D_CHECKSUM_EN
    logic [7:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (state_q == TX_WAIT && ack_from_next) begin
            checksum_d = checksum_q ^ data_out_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

    assign ack_prev = ack_prev_q;
    assign DOR      = dor_q;
    assign data_out = data_out_q;
    assign count    = count_q;
    assign full     = full_q;
    assign empty    = empty_q;

endmodule

// File: tb/tb_stage_d_fifo.sv
// Scoreboard bench for stage_d_fifo: directed upstream/downstream sequences,
// second instance with INCREMENT=3 shares inputs and runs in lockstep.
module tb_stage_d_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       DIR;
    logic [7:0] data_in;
    logic       ack_from_next;
    logic       ack_prev, DOR, full, empty;
    logic [7:0] data_out;
    logic [2:0] count;
    logic       ack_prev3, DOR3, full3, empty3;
    logic [7:0] data_out3;
    logic [2:0] count3;
`ifdef STAGE_D_CHECKSUM_EN
    logic [7:0] checksum, checksum3;
`endif

    stage_d_fifo #(.DEPTH(4), .INCREMENT(8'd1)) u_dut (
        .clk(clk), .reset(reset), .DIR(DIR), .data_in(data_in),
        .ack_prev(ack_prev), .DOR(DOR), .data_out(data_out),
        .ack_from_next(ack_from_next),
`ifdef STAGE_D_CHECKSUM_EN
        .checksum(checksum),
`endif
        .count(count), .full(full), .empty(empty)
    );

    stage_d_fifo #(.DEPTH(4), .INCREMENT(8'd3)) u_dut3 (
        .clk(clk), .reset(reset), .DIR(DIR), .data_in(data_in),
        .ack_prev(ack_prev3), .DOR(DOR3), .data_out(data_out3),
        .ack_from_next(ack_from_next),
`ifdef STAGE_D_CHECKSUM_EN
        .checksum(checksum3),
`endif
        .count(count3), .full(full3), .empty(empty3)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         ack_cyc = 0;
    int         rise_cyc = 0;
    int         mcount = 0;
    int         wait_cnt = 0;
    int         n;
    bit         sink_en = 0;
    bit         rnd = 0;
    bit         prev_ack = 0;
    bit         prev_dor = 0;
    logic [7:0] chk_model = '0;
    logic [7:0] src[$];
    logic [7:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [7:0] w, e1, e3;
        @(posedge clk);
        #1;
        cyc++;
        chk("ack_pulse", 32'(ack_prev & prev_ack), 32'd0);
        if (ack_prev) begin
            if (DIR) begin
                sb.push_back(data_in);
                mcount++;
                ack_cyc = cyc;
            end
            DIR = 1'b0;
        end else if (!DIR && src.size() > 0) begin
            DIR     = 1'b1;
            data_in = src.pop_front();
        end
        if (ack_from_next) begin
            ack_from_next = 1'b0;
            chk("dor_drop", 32'(DOR), 32'd0);
        end else if (DOR) begin
            if (!prev_dor) begin
                rise_cyc = cyc;
                mcount--;
                if (sb.size() == 0) begin
                    chk("spurious_word", 32'(sb.size()), 32'd1);
                end else begin
                    w  = sb.pop_front();
                    e1 = w + 8'd1;
                    e3 = w + 8'd3;
                    chk("data_out", 32'(data_out), 32'(e1));
                    chk("data_out_inc3", 32'(data_out3), 32'(e3));
                end
                wait_cnt = rnd ? int'($urandom_range(0, 3)) : 0;
            end
            if (sink_en) begin
                if (wait_cnt == 0) begin
                    ack_from_next = 1'b1;
                    chk_model     = chk_model ^ data_out;
                end else begin
                    wait_cnt--;
                end
            end
        end
        if (!DOR) chk("data_out_idle", 32'(data_out), 32'd0);
        chk("count", 32'(count), 32'(mcount));
        chk("full", 32'(full), 32'(mcount == 4));
        chk("empty", 32'(empty), 32'(mcount == 0));
        prev_ack = ack_prev;
        prev_dor = DOR;
    endtask

    task automatic drain(input int max);
        int k = 0;
        while ((src.size() > 0 || sb.size() > 0 || DIR || DOR ||
                ack_from_next) && k < max) begin
            tick();
            k++;
        end
        chk("drain_timeout", 32'(k >= max), 32'd0);
`ifdef STAGE_D_CHECKSUM_EN
        chk("checksum", 32'(checksum), 32'(chk_model));
`endif
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        DIR           = 1'b0;
        ack_from_next = 1'b0;
        data_in       = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_ack_prev", 32'(ack_prev), 32'd0);
        chk("rst_dor", 32'(DOR), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
`ifdef STAGE_D_CHECKSUM_EN
        chk("rst_checksum", 32'(checksum), 32'd0);
`endif
        src.delete();
        sb.delete();
        mcount    = 0;
        wait_cnt  = 0;
        prev_ack  = 0;
        prev_dor  = 0;
        chk_model = '0;
    endtask

    initial begin
        reset         = 1'b1;
        DIR           = 1'b0;
        data_in       = '0;
        ack_from_next = 1'b0;
        do_reset();

        // single word, fall-through latency
        sink_en = 1;
        src.push_back(8'd5);
        drain(50);
        chk("fall_through", 32'(rise_cyc - ack_cyc), 32'd1);

        // fill with stalled sink; sixth word must be held off
        sink_en = 0;
        for (int i = 10; i <= 15; i++) src.push_back(8'(i));
        n = 0;
        while (!(count == 3'd4 && DOR) && n < 60) begin
            tick();
            n++;
        end
        repeat (4) tick();
        chk("full_flag", 32'(full), 32'd1);
        chk("full_count", 32'(count), 32'd4);
        chk("full_dir_held", 32'(DIR), 32'd1);
        chk("full_no_ack", 32'(ack_prev), 32'd0);
        chk("full_word", 32'(data_in), 32'd15);
        sink_en = 1;
        n = 0;
        while (!ack_prev && n < 10) begin
            tick();
            n++;
        end
        chk("refill_latency", 32'(n <= 4), 32'd1);
        drain(100);

        // ordered stream with random downstream delay
        rnd = 1;
        for (int i = 0; i < 20; i++) src.push_back(8'(i));
        drain(600);
        rnd = 0;

        // carry discarded
        src.push_back(8'hFF);
        src.push_back(8'hFE);
        drain(50);

        // push and pop on the same edge with count=2
        sink_en = 0;
        src.push_back(8'd50);
        src.push_back(8'd51);
        src.push_back(8'd52);
        n = 0;
        while (!(count == 3'd2 && DOR && !DIR && src.size() == 0) && n < 60) begin
            tick();
            n++;
        end
        sink_en = 1;
        tick();
        tick();
        DIR     = 1'b1;
        data_in = 8'd53;
        sink_en = 0;
        tick();
        chk("simul_count", 32'(count), 32'd2);
        chk("simul_ack", 32'(ack_prev), 32'd1);
        chk("simul_dor", 32'(DOR), 32'd1);
        sink_en = 1;
        drain(100);

        // reset with words stored and one in flight
        sink_en = 0;
        for (int i = 30; i <= 33; i++) src.push_back(8'(i));
        n = 0;
        while (!(count == 3'd3 && DOR && !DIR && src.size() == 0) && n < 60) begin
            tick();
            n++;
        end
        chk("pre_reset_count", 32'(count), 32'd3);
        do_reset();
        sink_en = 1;
        src.push_back(8'd40);
        drain(50);
        src.push_back(8'd0);
        src.push_back(8'd1);
        src.push_back(8'd2);
        drain(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
